// File: rtl/char_colorizer_if.sv
// Register-write port for char_colorizer: one write per cycle while cfg_we is high.
interface char_colorizer_if;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_wdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/char_colorizer.sv
// Colours a text-mode glyph stream inside a programmable window; config is double-buffered at frame start.
// Optional glyph blinking is compiled in with `define CHAR_COLORIZER_BLINK_EN.
module char_colorizer #(
    parameter int CHAR_LAT     = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              vga_clk,
    input  logic              reset,
    char_colorizer_if.slave   cfg,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [11:0]       pixel_row,
    input  logic [11:0]       pixel_column,
    input  logic              char_pix,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              video_on_out
);

    typedef struct packed {
        logic [11:0] fg;
        logic [11:0] bg;
        logic [11:0] win_x;
        logic [11:0] win_y;
        logic [11:0] win_w;
        logic [11:0] win_h;
    } cfg_t;

    localparam cfg_t CFG_RST = '{fg: 12'hFFF, bg: 12'h000, win_x: 12'd0, win_y: 12'd0,
                                 win_w: 12'd640, win_h: 12'd480};

    logic [CHAR_LAT-1:0]        vid_pipe_q, vid_pipe_d;
    logic [CHAR_LAT-1:0]        hs_pipe_q, hs_pipe_d;
    logic [CHAR_LAT-1:0]        vs_pipe_q, vs_pipe_d;
    logic [CHAR_LAT-1:0][11:0]  row_pipe_q, row_pipe_d;
    logic [CHAR_LAT-1:0][11:0]  col_pipe_q, col_pipe_d;

    cfg_t        shadow_q, shadow_d;
    cfg_t        active_q, active_d;
    logic        vs_prev_q, vs_prev_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic        vid_out_q, vid_out_d;

    logic        vid_a, hs_a, vs_a;
    logic [11:0] row_a, col_a;
    logic        frame_start;
    logic [12:0] x_end, y_end;
    logic        in_win;
    logic        glyph_on;

    assign vid_a = vid_pipe_q[CHAR_LAT-1];
    assign hs_a  = hs_pipe_q[CHAR_LAT-1];
    assign vs_a  = vs_pipe_q[CHAR_LAT-1];
    assign row_a = row_pipe_q[CHAR_LAT-1];
    assign col_a = col_pipe_q[CHAR_LAT-1];

    assign frame_start = vs_prev_q & ~vs_a;

    // 13-bit ends so a window near the right/bottom edge cannot wrap to column/row 0
    assign x_end  = {1'b0, active_q.win_x} + {1'b0, active_q.win_w};
    assign y_end  = {1'b0, active_q.win_y} + {1'b0, active_q.win_h};
    assign in_win = (col_a >= active_q.win_x) && ({1'b0, col_a} < x_end) &&
                    (row_a >= active_q.win_y) && ({1'b0, row_a} < y_end);

`ifdef CHAR_COLORIZER_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          hidden_q, hidden_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        if (frame_start) begin
            if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                hidden_d    = ~hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
        end
    end

    assign glyph_on = char_pix & ~hidden_q;
`else
    assign glyph_on = char_pix;
`endif

    always_comb begin
        vid_pipe_d    = vid_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        row_pipe_d    = row_pipe_q;
        col_pipe_d    = col_pipe_q;
        vid_pipe_d[0] = video_on;
        hs_pipe_d[0]  = hsync_in;
        vs_pipe_d[0]  = vsync_in;
        row_pipe_d[0] = pixel_row;
        col_pipe_d[0] = pixel_column;
        for (int i = 1; i < CHAR_LAT; i++) begin
            vid_pipe_d[i] = vid_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
            row_pipe_d[i] = row_pipe_q[i-1];
            col_pipe_d[i] = col_pipe_q[i-1];
        end

        shadow_d = shadow_q;
        if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                3'd0:    shadow_d.fg    = cfg.cfg_wdata;
                3'd1:    shadow_d.bg    = cfg.cfg_wdata;
                3'd2:    shadow_d.win_x = cfg.cfg_wdata;
                3'd3:    shadow_d.win_y = cfg.cfg_wdata;
                3'd4:    shadow_d.win_w = cfg.cfg_wdata;
                3'd5:    shadow_d.win_h = cfg.cfg_wdata;
                default: ;
            endcase
        end

        // Copy from shadow_q, so a write landing on frame start waits one more frame
        active_d  = frame_start ? shadow_q : active_q;
        vs_prev_d = vs_a;

        rgb_d = 12'h000;
        if (vid_a && in_win)
            rgb_d = glyph_on ? active_q.fg : active_q.bg;
        hs_out_d  = hs_a;
        vs_out_d  = vs_a;
        vid_out_d = vid_a;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vid_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            row_pipe_q <= '0;
            col_pipe_q <= '0;
            shadow_q   <= CFG_RST;
            active_q   <= CFG_RST;
            vs_prev_q  <= 1'b1;
            rgb_q      <= 12'h000;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
            vid_out_q  <= 1'b0;
        end else begin
            vid_pipe_q <= vid_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            row_pipe_q <= row_pipe_d;
            col_pipe_q <= col_pipe_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            vs_prev_q  <= vs_prev_d;
            rgb_q      <= rgb_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
            vid_out_q  <= vid_out_d;
        end
    end

    assign vga_r        = rgb_q[11:8];
    assign vga_g        = rgb_q[7:4];
    assign vga_b        = rgb_q[3:0];
    assign hsync_out    = hs_out_q;
    assign vsync_out    = vs_out_q;
    assign video_on_out = vid_out_q;

endmodule

// File: tb/tb_char_colorizer.sv
// Scoreboard bench for char_colorizer: stimulus queues expected outputs, a negedge monitor compares them.
module tb_char_colorizer;
    localparam int LAT = 3;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        video_on, hsync_in, vsync_in, char_pix;
    logic [11:0] pixel_row, pixel_column;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, video_on_out;

    char_colorizer_if cfg_if ();

    char_colorizer #(.CHAR_LAT(2), .BLINK_FRAMES(2)) dut (
        .vga_clk(vga_clk), .reset(reset), .cfg(cfg_if),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .char_pix(char_pix),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vid;
        string       nm;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [1:0] pdl    = 2'b00;

    // One call per clock; char_pix is replayed two cycles after its coordinates
    task automatic drive(input logic vid, input logic hs, input logic vs,
                         input logic [11:0] row, input logic [11:0] col, input logic pix,
                         input logic chk, input logic [11:0] rgb, input string nm);
        exp_t e;
        video_on = vid; hsync_in = hs; vsync_in = vs;
        pixel_row = row; pixel_column = col;
        char_pix = pdl[1];
        pdl = {pdl[0], pix};
        if (chk) begin
            e.due = cyc + LAT; e.rgb = rgb; e.hs = hs; e.vs = vs; e.vid = vid; e.nm = nm;
            sb.push_back(e);
        end
        @(posedge vga_clk); #1;
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic px(input logic [11:0] row, input logic [11:0] col, input logic pix,
                      input logic [11:0] rgb, input string nm);
        drive(1'b1, 1'b1, 1'b1, row, col, pix, 1'b1, rgb, nm);
    endtask

    task automatic idle(input int n, input logic chk);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, chk, 12'h000, "idle");
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d);
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_wdata = d;
    endtask

    // Vsync pulse; optional write lands exactly in the aligned frame-start cycle
    task automatic frame(input logic do_wr, input logic [2:0] a, input logic [11:0] d);
        drive(1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b1, 12'h000, "vs_hi");
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 12'h000, "vs_lo");
        drive(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 12'h000, "vs_lo");
        if (do_wr) wr(a, d);
        drive(1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b1, 12'h000, "vs_hi");
        drive(1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, 1'b1, 12'h000, "vs_hi");
    endtask

    task automatic rst_check(input string nm);
        @(negedge vga_clk);
        n_chk++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync_out !== 1'b1 ||
            vsync_out !== 1'b1 || video_on_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b vid=%b, expected rgb=000 hs=1 vs=1 vid=0",
                     nm, {vga_r, vga_g, vga_b}, hsync_out, vsync_out, video_on_out);
        end
        @(posedge vga_clk); #1;
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.due != cyc || {vga_r, vga_g, vga_b} !== e.rgb || hsync_out !== e.hs ||
                vsync_out !== e.vs || video_on_out !== e.vid) begin
                n_fail++;
                $display("FAIL %s @%0d: got rgb=%h hs=%b vs=%b vid=%b, expected rgb=%h hs=%b vs=%b vid=%b (due %0d)",
                         e.nm, cyc, {vga_r, vga_g, vga_b}, hsync_out, vsync_out, video_on_out,
                         e.rgb, e.hs, e.vs, e.vid, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 3'd0; cfg_if.cfg_wdata = 12'h000;
        video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; char_pix = 1'b0;
        pixel_row = 12'd0; pixel_column = 12'd0;
        @(posedge vga_clk); #1;
        idle(2, 1'b0);
        rst_check("reset_state");
        reset = 1'b0;

`ifndef CHAR_COLORIZER_BLINK_EN
        idle(3, 1'b1);
        frame(1'b0, 3'd0, 12'h000);
        // first active pixel, then a pixel pair with hsync low on the first
        px(12'd0, 12'd0, 1'b0, 12'h000, "first_vid");
        drive(1'b1, 1'b0, 1'b1, 12'd5, 12'd100, 1'b1, 1'b1, 12'hFFF, "fg_col100");
        px(12'd5, 12'd101, 1'b0, 12'h000, "bg_col101");

        // mid-frame writes stay in shadow until the next frame start
        wr(3'd0, 12'hF00); px(12'd5, 12'd102, 1'b1, 12'hFFF, "fg_before_frame");
        wr(3'd1, 12'h0A5); px(12'd5, 12'd103, 1'b0, 12'h000, "bg_before_frame");
        wr(3'd6, 12'h555); px(12'd5, 12'd104, 1'b1, 12'hFFF, "addr6_ignored");
        wr(3'd7, 12'h000); idle(1, 1'b1);
        frame(1'b0, 3'd0, 12'h000);
        px(12'd6, 12'd100, 1'b1, 12'hF00, "fg_after_frame");
        px(12'd6, 12'd101, 1'b0, 12'h0A5, "bg_after_frame");

        // window x 8..15, y 10..11
        wr(3'd2, 12'd8);  idle(1, 1'b1);
        wr(3'd4, 12'd8);  idle(1, 1'b1);
        wr(3'd3, 12'd10); idle(1, 1'b1);
        wr(3'd5, 12'd2);  idle(1, 1'b1);
        frame(1'b0, 3'd0, 12'h000);
        px(12'd10, 12'd7,  1'b1, 12'h000, "win_col7");
        px(12'd10, 12'd8,  1'b1, 12'hF00, "win_col8");
        px(12'd10, 12'd15, 1'b0, 12'h0A5, "win_col15_bg");
        px(12'd10, 12'd16, 1'b1, 12'h000, "win_col16");
        px(12'd10, 12'd15, 1'b1, 12'hF00, "win_col15_fg");
        px(12'd9,  12'd8,  1'b1, 12'h000, "win_row9");
        px(12'd11, 12'd8,  1'b1, 12'hF00, "win_row11");
        px(12'd12, 12'd8,  1'b1, 12'h000, "win_row12");
        drive(1'b0, 1'b1, 1'b1, 12'd10, 12'd8, 1'b1, 1'b1, 12'h000, "video_off");

        wr(3'd4, 12'd0); idle(1, 1'b1);
        frame(1'b0, 3'd0, 12'h000);
        px(12'd10, 12'd8, 1'b1, 12'h000, "empty_win");

        // window x 0xFF8..0x1007 must not wrap onto column 0
        wr(3'd2, 12'hFF8); idle(1, 1'b1);
        wr(3'd4, 12'd16);  idle(1, 1'b1);
        frame(1'b0, 3'd0, 12'h000);
        px(12'd10, 12'h000, 1'b1, 12'h000, "no_wrap_col0");
        px(12'd10, 12'hFF7, 1'b1, 12'h000, "edge_colFF7");
        px(12'd10, 12'hFFF, 1'b1, 12'hF00, "edge_colFFF");

        frame(1'b1, 3'd0, 12'h0F0);
        px(12'd10, 12'hFFF, 1'b1, 12'hF00, "wr_at_start_absent");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd10, 12'hFFF, 1'b1, 12'h0F0, "wr_at_start_present");

        // reset mid-frame with a write in flight
        idle(3, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 12'd10, 12'hFFF, 1'b1, 1'b0, 12'h000, "pre_rst");
        drive(1'b1, 1'b0, 1'b1, 12'd10, 12'hFFF, 1'b1, 1'b0, 12'h000, "pre_rst");
        reset = 1'b1;
        wr(3'd0, 12'h123);
        drive(1'b1, 1'b0, 1'b1, 12'd10, 12'hFFF, 1'b1, 1'b0, 12'h000, "in_rst");
        rst_check("reset_mid_frame");
        reset = 1'b0;
        idle(3, 1'b1);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "post_rst_fg");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd479, 12'd639, 1'b1, 12'hFFF, "def_win_corner");
        px(12'd5,   12'd640, 1'b1, 12'h000, "def_win_col640");
        px(12'd480, 12'd5,   1'b1, 12'h000, "def_win_row480");
`else
        idle(3, 1'b1);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "blink_f0");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "blink_f1");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'h000, "blink_f2");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'h000, "blink_f3");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "blink_f4");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "blink_f5");
        frame(1'b0, 3'd0, 12'h000);
        px(12'd0, 12'd0, 1'b1, 12'h000, "blink_f6");
        idle(3, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 12'h000, "in_rst");
        rst_check("reset_mid_frame");
        reset = 1'b0;
        idle(3, 1'b1);
        px(12'd0, 12'd0, 1'b1, 12'hFFF, "blink_visible_after_rst");
`endif

        idle(3, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge vga_clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/char_colorizer.md
CHAR_COLORIZER -- requirements
Module: char_colorizer

Interface
REQ-001 SHALL have parameter CHAR_LAT, default 2, giving cycles from pixel coordinates to the matching char_pix input.
REQ-002 SHALL have parameter BLINK_FRAMES, default 32, giving frames per blink half-period.
REQ-003 SHALL have port vga_clk, input, 1, the only clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port video_on, input, 1, active-video flag aligned with pixel_row/pixel_column.
REQ-006 SHALL have ports hsync_in and vsync_in, input, 1 each, active-low syncs aligned with pixel_row/pixel_column.
REQ-007 SHALL have ports pixel_row and pixel_column, input, 12 each, current pixel coordinates.
REQ-008 SHALL have port char_pix, input, 1, glyph bit arriving CHAR_LAT cycles after its coordinates.
REQ-009 SHALL have ports cfg_we (1), cfg_addr (3) and cfg_wdata (12), input, forming a single-cycle register write port.
REQ-010 SHALL have ports vga_r, vga_g and vga_b, output, 4 each, colour out.
REQ-011 SHALL have ports hsync_out, vsync_out and video_on_out, output, 1 each, delayed timing signals.

Function
REQ-012 SHALL delay video_on, hsync_in, vsync_in, pixel_row and pixel_column through a CHAR_LAT-deep shift pipeline so they align with char_pix.
REQ-013 SHALL register all outputs once after alignment, giving a total latency of CHAR_LAT+1 cycles from input timing to output.
REQ-014 SHALL hold six shadow registers selected by cfg_addr: 0 fg colour, 1 bg colour, 2 win_x, 3 win_y, 4 win_w, 5 win_h; writes to addresses 6 and 7 SHALL be ignored.
REQ-015 SHALL copy all shadow registers into active registers at frame start, defined as the aligned vsync falling edge (1 to 0).
REQ-016 SHALL, when cfg_we is high in the same cycle as frame start, load the pre-write shadow value into the active registers; the new value takes effect at the following frame start.
REQ-017 SHALL treat an aligned pixel as in-window when win_x <= col < win_x+win_w and win_y <= row < win_y+win_h, with both sums computed at 13 bits so there is no wrap.
REQ-018 SHALL treat win_w=0 or win_h=0 as an empty window.
REQ-019 SHALL drive colour 0x000 when aligned video_on is 0.
REQ-020 SHALL drive colour 0x000 when the pixel is outside the window.
REQ-021 SHALL otherwise drive fg when the glyph bit is 1 and bg when it is 0.
REQ-022 SHALL map a 12-bit colour as {r[11:8], g[7:4], b[3:0]}.

Reset
REQ-023 SHALL set the following values when reset is high at a clock edge:
- vga_r/g/b = 0, hsync_out = 1, vsync_out = 1, video_on_out = 0;
- delay pipeline cleared to video_on = 0, syncs = 1, coordinates = 0;
- shadow and active registers: fg 0xFFF, bg 0x000, win 0/0/640/480;
- blink counter = 0, blink phase = visible.
REQ-024 SHALL take effect on any cycle, including mid-frame and mid-write; a write coinciding with reset SHALL be discarded.

Configuration
REQ-025 SHALL compile blink support in when CHAR_COLORIZER_BLINK_EN is defined:
- a frame counter increments at each frame start;
- at BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase;
- while the phase is hidden, in-window pixels SHALL output bg regardless of the glyph bit.
REQ-026 SHALL, when the macro is undefined, contain no counter or phase logic; glyphs are always visible.

Verification
REQ-027 Reset then idle timing: outputs are 0x000 with syncs at 1; first video_on=1 appears on video_on_out exactly 3 cycles after input (CHAR_LAT=2).
REQ-028 Window 0/0/640/480 with char_pix pattern 1,0 at col 100,101 -> outputs 0xFFF then 0x000, 3 cycles after the coordinates.
REQ-029 Write fg=0xF00 mid-frame -> current frame still shows 0xFFF; frame after the next vsync falling edge shows 0xF00.
REQ-030 Write win_x=8, win_w=8 -> col 7 and col 16 output 0x000; col 8 and col 15 follow char_pix.
REQ-031 cfg_we in the same cycle as frame start -> new value is absent for that frame and present in the next.
REQ-032 With CHAR_COLORIZER_BLINK_EN and BLINK_FRAMES=2, char_pix held at 1 in-window -> fg for frames 0-1, bg for frames 2-3, fg again at frame 4; reset mid-frame returns the phase to visible.
